// File: rtl/seq_restoring_div_if.sv
// Handshake bundle for seq_restoring_div: start/operands in, result/status out.
interface seq_restoring_div_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  modport master (output start, a, b, input q, r, busy, done, dz);
  modport slave  (input start, a, b, output q, r, busy, done, dz);
endinterface

// File: rtl/seq_restoring_div.sv
// Unsigned restoring divider, one quotient bit per clock (q = a / b, r = a % b).
// Define DIVZERO_DETECT_EN to short-cut b == 0 straight to DONE and raise dz.
module seq_restoring_div #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_restoring_div_if.slave io
);

`ifdef DIVZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  qs_q, qs_d;
  logic [N-1:0]  bs_q, bs_d;
  logic [N:0]    rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          zpend_q, zpend_d;

  logic [N:0]    shifted;
  logic [N+1:0]  trial;
  logic          no_borrow;

  // Trial subtract as shifted + ~B + 1; the carry out is the "no borrow" flag.
  always_comb begin
    shifted   = {rs_q[N-1:0], qs_q[N-1]};
    trial     = {1'b0, shifted} + {1'b0, ~{1'b0, bs_q}} + (N+2)'(1);
    no_borrow = trial[N+1];
  end

  always_comb begin
    state_d = state_q;
    qs_d    = qs_q;
    bs_d    = bs_q;
    rs_d    = rs_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    zpend_d = zpend_q;

    case (state_q)
      IDLE, DONE: begin
        if (io.start) begin
          qs_d    = io.a;
          bs_d    = io.b;
          rs_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          dz_d    = 1'b0;
          zpend_d = DZ_EN && (io.b == '0);
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (zpend_q) begin
          // Zero divisor: report the same q/r the full algorithm would give.
          q_d     = '1;
          r_d     = qs_q;
          dz_d    = 1'b1;
          zpend_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(N)) begin
          q_d     = qs_q;
          r_d     = rs_q[N-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          rs_d  = no_borrow ? trial[N:0] : shifted;
          qs_d  = {qs_q[N-2:0], no_borrow};
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      qs_q    <= '0;
      bs_q    <= '0;
      rs_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qs_q    <= qs_d;
      bs_q    <= bs_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      zpend_q <= zpend_d;
    end
  end

  assign io.q    = q_q;
  assign io.r    = r_q;
  assign io.busy = busy_q;
  assign io.done = done_q;
`ifdef DIVZERO_DETECT_EN
  assign io.dz   = dz_q;
`else
  assign io.dz   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed bench for seq_restoring_div at N=4: handshake timing, results, reset abort, b=0.
module tb_seq_restoring_div;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   lat;
  int   bcnt;

  seq_restoring_div_if #(.N(N)) io ();

  seq_restoring_div #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait from the cycle after the start edge until done, bounded; lat counts that cycle as 1.
  task automatic wait_done(output int l, output int busy_cycles);
    l = 1;
    busy_cycles = 0;
    while (io.done !== 1'b1 && l < 20) begin
      if (io.busy === 1'b1) busy_cycles++;
      step();
      l++;
    end
  endtask

  // Launch one divide from idle and return after the done cycle has been sampled.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, output int l, output int bc);
    io.start = 1'b1;
    io.a = a;
    io.b = b;
    step();
    io.start = 1'b0;
    wait_done(l, bc);
  endtask

  initial begin
    io.start = 1'b0;
    io.a = '0;
    io.b = '0;

    // Reset state
    step();
    chk("rst_q", io.q, 0);
    chk("rst_r", io.r, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_dz", io.dz, 0);
    rst_n = 1'b1;
    step();

    // 13 / 3: latency, busy window, result
    run_div(4'b1101, 4'b0011, lat, bcnt);
    chk("lat_13_3", lat, 6);
    chk("busy_cycles_13_3", bcnt, 5);
    chk("q_13_3", io.q, 4'b0100);
    chk("r_13_3", io.r, 4'b0001);
    chk("busy_in_done", io.busy, 0);
    chk("dz_13_3", io.dz, 0);
    step();
    chk("done_one_cycle", io.done, 0);
    chk("q_hold", io.q, 4'b0100);

    // Reset mid-RUN after two iterations aborts the operation
    io.start = 1'b1;
    io.a = 4'b1101;
    io.b = 4'b0011;
    step();
    io.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_q", io.q, 0);
    chk("abort_r", io.r, 0);
    chk("abort_busy", io.busy, 0);
    chk("abort_done", io.done, 0);
    step();
    rst_n = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (io.done === 1'b1 || io.busy === 1'b1) bcnt++;
    end
    chk("abort_no_done", bcnt, 0);

    // Directed vectors
    run_div(4'b1111, 4'b0001, lat, bcnt);
    chk("q_15_1", io.q, 4'b1111);
    chk("r_15_1", io.r, 4'b0000);
    step();
    run_div(4'b0101, 4'b1011, lat, bcnt);
    chk("lat_5_11", lat, 6);
    chk("q_5_11", io.q, 4'b0000);
    chk("r_5_11", io.r, 4'b0101);
    step();
    run_div(4'b1111, 4'b1111, lat, bcnt);
    chk("q_15_15", io.q, 4'b0001);
    chk("r_15_15", io.r, 4'b0000);
    step();

    // start pulsed during RUN with other operands is ignored
    io.start = 1'b1;
    io.a = 4'b1101;
    io.b = 4'b0011;
    step();
    io.start = 1'b0;
    step();
    io.start = 1'b1;
    io.a = 4'b0111;
    io.b = 4'b0010;
    step();
    io.start = 1'b0;
    wait_done(lat, bcnt);
    chk("ign_lat", lat, 4);
    chk("ign_q", io.q, 4'b0100);
    chk("ign_r", io.r, 4'b0001);
    step();
    chk("ign_idle", io.busy, 0);
    step();

    // Back-to-back: start held through done, new operands in the done cycle
    io.start = 1'b1;
    io.a = 4'b1101;
    io.b = 4'b0011;
    step();
    wait_done(lat, bcnt);
    chk("b2b_lat1", lat, 6);
    chk("b2b_q1", io.q, 4'b0100);
    chk("b2b_r1", io.r, 4'b0001);
    io.a = 4'b1000;
    io.b = 4'b0101;
    step();
    io.start = 1'b0;
    chk("b2b_busy_next", io.busy, 1);
    chk("b2b_done_next", io.done, 0);
    wait_done(lat, bcnt);
    chk("b2b_lat2", lat, 6);
    chk("b2b_q2", io.q, 4'b0001);
    chk("b2b_r2", io.r, 4'b0011);
    step();

    // Divide by zero
    run_div(4'b1000, 4'b0000, lat, bcnt);
    chk("dz_q", io.q, 4'b1111);
    chk("dz_r", io.r, 4'b1000);
`ifdef DIVZERO_DETECT_EN
    chk("dz_lat", lat, 2);
    chk("dz_flag", io.dz, 1);
    step();
    chk("dz_hold", io.dz, 1);
    io.start = 1'b1;
    io.a = 4'b0110;
    io.b = 4'b0010;
    step();
    io.start = 1'b0;
    chk("dz_clear", io.dz, 0);
    wait_done(lat, bcnt);
    chk("dz_after_q", io.q, 4'b0011);
`else
    chk("dz_lat", lat, 6);
    chk("dz_flag", io.dz, 0);
`endif
    step();

    // Exhaustive sweep, b != 0
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        run_div(4'(ai), 4'(bi), lat, bcnt);
        chk($sformatf("sweep_q_%0d_%0d", ai, bi), io.q, 32'(ai / bi));
        chk($sformatf("sweep_r_%0d_%0d", ai, bi), io.r, 32'(ai % bi));
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
